xor_share_arbiter: RTL and testbench
====================================

// Module: xor_share_arbiter
// PURPOSE
//   Shares one registered xor_gate-style XOR unit among N_REQ requesters using round-robin arbitration.
//   Grants one requester, captures its operands, computes a^b, and holds the result on a valid/ready port until it is consumed.
//   Sits between the requesting blocks and the shared XOR datapath; it is the only writer of that datapath.
// PARAMETERS
//   N_REQ  4   number of requesters (2..16)
//   WIDTH  8   operand/result width in bits
//   CNT_W  16  width of completed-operation counter
// PORTS
//   clk        in   1              single clock, rising edge
//   rst_n      in   1              asynchronous, active-low reset
//   req        in   N_REQ          req[i]=1: requester i has operands pending
//   a_bus      in   N_REQ*WIDTH    operand A, slice i = a_bus[i*WIDTH +: WIDTH]
//   b_bus      in   N_REQ*WIDTH    operand B, same slicing
//   gnt        out  N_REQ          one-hot grant pulse; operands sampled at this edge
//   res_valid  out  1              result available
//   res_ready  in   1              consumer accepts result
//   res_data   out  WIDTH          a^b of granted requester
//   res_id     out  $clog2(N_REQ)  index of granted requester
//   busy       out  1              1 while state != IDLE
//   ops_done   out  CNT_W          count of completed res handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (async assert, sync deassert at the edge):
//     state=IDLE, rr_ptr=0, res_valid=0, res_data=0, res_id=0, ops_done=0, gnt=0.
//   FSM has two states: IDLE and HOLD.
//   IDLE:
//     gnt is combinational, comes from req and rr_ptr, and is nonzero only in IDLE.
//     If req!=0, gnt is one-hot for the first set req[k] at or after rr_ptr (ascending index, wrapping).
//     At that edge: res_data <= a_k^b_k; res_id <= k; res_valid <= 1; rr_ptr <= (k+1) mod N_REQ; state -> HOLD.
//     If req==0: gnt=0, stay in IDLE, rr_ptr unchanged.
//   HOLD:
//     gnt=0. res_data and res_id stay stable while res_valid=1 && !res_ready.
//     On res_valid && res_ready: res_valid <= 0; ops_done <= ops_done+1; state -> IDLE.
//     There is no grant in the same cycle as the handshake.
//   Latency and throughput:
//     Grant at edge E gives res_valid=1 from E until the handshake edge.
//     Minimum period is 2 cycles per operation (grant cycle, then handshake cycle).
//   Requester rules:
//     Hold req and operands stable until gnt is seen; drop req the cycle after gnt unless another op is pending.
//     A req deasserted before its gnt is a legal withdrawal; no result is produced for it.
//   Fairness: a requester with req held continuously is granted within N_REQ grants.
//   Boundaries:
//     N_REQ=1 degenerates to fixed grant with rr_ptr held at 0.
//     rr_ptr wraps from N_REQ-1 to 0.
//     ops_done wraps from all-ones to 0.
//     If res_ready is held high, the result still appears for exactly one cycle.
//   Reset mid-HOLD discards the pending result; res_valid drops immediately, without waiting for a clock edge.
//   No X propagation: when res_valid=0, res_data keeps its last value.
// STRUCTURE
//   Package xor_arb_pkg holds:
//     state typedef {IDLE, HOLD}, 1 bit;
//     the ID width function clog2_min1 (returns >=1 so N_REQ=1 is legal);
//     default parameter constants.
//   Sub-module rr_pick(N_REQ):
//     combinational round-robin picker; inputs req and ptr; outputs one-hot gnt, index k, any.
//   The top holds the FSM, the operand mux, the XOR register, rr_ptr and ops_done.
// TESTING
//   Assertions: gnt is one-hot or zero; gnt is zero in HOLD; res_data/res_id are stable while valid && !ready.
//   1. Reset, then req=4'b0001, a0=8'hA5, b0=8'h0F, res_ready=1:
//      gnt=0001 at edge 1; res_valid=1, res_data=8'hAA, res_id=0 after it; ops_done=1 after edge 2.
//   2. req=4'b1111 held, res_ready=1, operands a_i=i, b_i=8'hFF:
//      grant order 0,1,2,3,0; res_data sequence FF,FE,FD,FC,FF; one grant every 2 cycles.
//   3. Backpressure: res_ready=0 for 5 cycles after a grant:
//      res_valid stays 1, res_data is unchanged, gnt=0 throughout; the next grant comes only after the handshake.
//   4. Wrap: rr_ptr=3 after granting 2, then req=4'b0101: grant goes to 0 (not 2), then to 2.
//   5. Reset mid-HOLD: assert rst_n=0 while res_valid=1:
//      res_valid=0 immediately and ops_done=0; after release with req=4'b0010, the first grant is 1.
//   6. ops_done wrap: run 2^CNT_W+1 handshakes (CNT_W=4 build): ops_done reads 1.

Source files
------------

// File: rtl/xor_arb_pkg.sv
// Shared types, defaults and helpers for the XOR-sharing round-robin arbiter.
package xor_arb_pkg;

  // Two-state controller: waiting for a request, or holding a result.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // Index width that never collapses to zero, so a single-requester build still has a port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xor_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import xor_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] w_idx;
  logic            w_any;

  // Scan offsets from farthest to nearest so the nearest requester wins the last assignment.
  always_comb begin
    int cand;
    w_idx = '0;
    w_any = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (req[cand]) begin
        w_idx = ID_W'(cand);
        w_any = 1'b1;
      end
    end
  end

  // Expand the chosen index to a one-hot grant, or all zeros when nothing is requested.
  always_comb begin
    gnt = '0;
    if (w_any) begin
      gnt[w_idx] = 1'b1;
    end
  end

  assign idx = w_idx;
  assign any = w_any;

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one registered XOR unit among N_REQ requesters,
// with the result held on a valid/ready port until consumed.
module xor_share_arbiter
  import xor_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int ID_W = clog2_min1(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       ops_done
);

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [ID_W-1:0]  r_id;
  logic [CNT_W-1:0] r_ops;

  logic [N_REQ-1:0] w_pick_gnt;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic [ID_W-1:0]  w_ptr_next;
  logic [WIDTH-1:0] w_a_arr [N_REQ];
  logic [WIDTH-1:0] w_b_arr [N_REQ];
  logic [WIDTH-1:0] w_xor;
  logic             w_grant;

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign w_a_arr[gi] = a_bus[gi*WIDTH +: WIDTH];
    assign w_b_arr[gi] = b_bus[gi*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req(req),
    .ptr(r_ptr),
    .gnt(w_pick_gnt),
    .idx(w_idx),
    .any(w_any)
  );

  // A grant only happens from IDLE; HOLD masks the picker entirely.
  assign w_grant    = (r_state == IDLE) && w_any;
  assign gnt        = (r_state == IDLE) ? w_pick_gnt : '0;
  assign w_xor      = w_a_arr[w_idx] ^ w_b_arr[w_idx];
  assign w_ptr_next = ID_W'((int'(w_idx) + 1) % N_REQ);

  // Controller: capture the granted operands' XOR, then hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_ops   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_data  <= w_xor;
            r_id    <= w_idx;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_next;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_valid && res_ready) begin
            r_valid <= 1'b0;
            r_ops   <= r_ops + CNT_W'(1);
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign busy      = (r_state == HOLD);
  assign ops_done  = r_ops;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Self-checking bench for xor_share_arbiter: directed scenarios plus a random
// phase, all compared against a transaction-level reference model.
module tb_xor_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*W-1:0] a_bus;
  logic [N*W-1:0] b_bus;
  logic [N-1:0]  gnt;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [1:0]    res_id;
  logic          busy;
  logic [CW-1:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (transaction level).
  int       m_ptr;
  int       m_ops;
  bit       m_hold;
  bit [7:0] m_data;
  int       m_id;

  xor_share_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Structural invariants, sampled mid-low-phase when inputs have settled.
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      chk("inv_gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      if (busy) chk("inv_gnt_zero_in_hold", {28'd0, gnt}, 32'd0);
    end
  end

  // First pending requester at or after ptr, ascending with wrap; -1 if none.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int off = 0; off < N; off++) begin
      if (r[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] lane(input logic [N*W-1:0] bus, input int i);
    return bus[i*W +: W];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_ops = 0; m_hold = 0; m_data = 8'h00; m_id = 0;
  endtask

  // One clock: check combinational grant, advance model at the edge, check registered outputs.
  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic cycle();
    int k;
    logic [N-1:0] eg;
    #1;
    k  = m_hold ? -1 : pick(req, m_ptr);
    eg = (k >= 0) ? (N'(1) << k) : '0;
    chk("gnt", {28'd0, gnt}, {28'd0, eg});
    @(posedge clk);
    if (k >= 0) begin
      m_data = lane(a_bus, k) ^ lane(b_bus, k);
      m_id   = k;
      m_ptr  = (k + 1) % N;
      m_hold = 1;
      $display("[%0t] grant id=%0d data=%02h", $time, k, m_data);
    end else if (m_hold && res_ready) begin
      m_hold = 0;
      m_ops  = (m_ops + 1) % (1 << CW);
      $display("[%0t] handshake id=%0d data=%02h ops=%0d", $time, m_id, m_data, m_ops);
    end
    #1;
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_hold});
    chk("res_data",  {24'd0, res_data},  {24'd0, m_data});
    chk("res_id",    {30'd0, res_id},    32'(m_id));
    chk("ops_done",  {28'd0, ops_done},  32'(m_ops));
    chk("busy",      {31'd0, busy},      {31'd0, m_hold});
    @(negedge clk);
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear without an edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_ops_done",  {28'd0, ops_done},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_res_data",  {24'd0, res_data},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; a_bus = '0; b_bus = '0; res_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1. Single requester, ready held high.
    req = 4'b0001; res_ready = 1'b1;
    a_bus[7:0] = 8'hA5; b_bus[7:0] = 8'h0F;
    cycle();
    chk("t1_data_AA", {24'd0, res_data}, 32'h0000_00AA);
    req = 4'b0000;
    cycle();
    chk("t1_ops_1", {28'd0, ops_done}, 32'd1);

    // 2. All requesting, a_i=i, b_i=FF: order 0,1,2,3,0 starting from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_bus[i*W +: W] = 8'(i);
      b_bus[i*W +: W] = 8'hFF;
    end
    req = 4'b1111; res_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("t2_last_id", {30'd0, res_id}, 32'd0);
    chk("t2_last_data", {24'd0, res_data}, 32'h0000_00FF);

    // 3. Backpressure for five cycles after a grant.
    req = 4'b0100; res_ready = 1'b0;
    cycle();
    req = 4'b0000;
    for (int i = 0; i < 5; i++) cycle();
    res_ready = 1'b1;
    cycle();
    cycle();

    // 4. Pointer wrap: grant 2 leaves ptr=3, then {0,2} requesting goes to 0 first.
    do_reset();
    req = 4'b0100; res_ready = 1'b1;
    cycle();
    req = 4'b0000;
    cycle();
    req = 4'b0101;
    cycle();
    chk("t4_wrap_id0", {30'd0, res_id}, 32'd0);
    req = 4'b0100;
    cycle();
    cycle();
    chk("t4_then_id2", {30'd0, res_id}, 32'd2);
    req = 4'b0000;
    cycle();

    // 5. Reset while a result is pending.
    req = 4'b1000; res_ready = 1'b0;
    cycle();
    req = 4'b0000;
    cycle();
    do_reset();
    req = 4'b0010; res_ready = 1'b1;
    cycle();
    chk("t5_first_id1", {30'd0, res_id}, 32'd1);
    req = 4'b0000;
    cycle();

    // 6. Counter wrap: 2^CW + 1 handshakes from reset.
    do_reset();
    req = 4'b0001; res_ready = 1'b1;
    for (int i = 0; i < 2 * ((1 << CW) + 1); i++) cycle();
    req = 4'b0000;
    chk("t6_ops_wrap", {28'd0, ops_done}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      req       = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      a_bus     = $urandom;
      b_bus     = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
